// File: rtl/tile_rd_addr_gen.sv
// Avalon-MM read master that walks a 2-D tile: N1_MAX rows of N0_MAX words,
// one single-word read per address. Returned beats are only counted.
module tile_rd_addr_gen #(
    parameter int AW       = 32,
    parameter int CW       = 16,
    parameter int N0_MAX   = 64,
    parameter int N1_MAX   = 16,
    parameter int BYTES    = 4,
    parameter int MAX_PEND = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW-1:0] row_stride_i,
    input  logic          fifo_almost_full_i,
    output logic [AW-1:0] avm_address_o,
    output logic          avm_read_o,
    input  logic          avm_waitrequest_i,
    input  logic          avm_readdatavalid_i,
    output logic          busy_o,
    output logic          done_o
);
    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] col_off_q, col_off_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          read_q, read_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic accept, dec, last, can_raise;

    always_comb begin
        accept    = read_q & ~avm_waitrequest_i;
        // a beat with nothing outstanding is ignored so the counter cannot underflow
        dec       = avm_readdatavalid_i & (pend_q != '0);
        pend_d    = pend_q + {{(PW-1){1'b0}}, accept} - {{(PW-1){1'b0}}, dec};
        last      = (row_q == CW'(N1_MAX - 1)) && (col_q == CW'(N0_MAX - 1));
        can_raise = (pend_d < PW'(MAX_PEND)) && !fifo_almost_full_i;

        state_d    = state_q;
        row_base_d = row_base_q;
        col_off_d  = col_off_q;
        stride_d   = stride_q;
        col_d      = col_q;
        row_d      = row_q;
        read_d     = read_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stride_d   = row_stride_i;
                    row_base_d = base_addr_i;
                    col_off_d  = '0;
                    col_d      = '0;
                    row_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    if (last) begin
                        read_d  = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        if (col_q == CW'(N0_MAX - 1)) begin
                            col_d      = '0;
                            col_off_d  = '0;
                            row_d      = row_q + 1'b1;
                            row_base_d = row_base_q + stride_q;
                        end else begin
                            col_d     = col_q + 1'b1;
                            col_off_d = col_off_q + AW'(BYTES);
                        end
                        read_d = can_raise;
                    end
                end else if (!read_q) begin
                    // a raised request is never withdrawn, so throttles only gate raising
                    read_d = can_raise;
                end
            end
            S_DRAIN: begin
                read_d = 1'b0;
                if (pend_d == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // counters only move on accept, so this holds the address while stalled
        addr_d = row_base_d + col_off_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_base_q <= '0;
            col_off_q  <= '0;
            stride_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pend_q     <= '0;
            addr_q     <= '0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_off_q  <= col_off_d;
            stride_q   <= stride_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign avm_address_o = addr_q;
    assign avm_read_o    = read_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
